// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the FP multiplier datapath blocks.
package fp_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MANT_W = 24;

endpackage

// File: rtl/mant_seq_mult_ctrl_if.sv
// Operand/product handshake bundle between unpack, the mantissa multiplier and normalize.
interface mant_seq_mult_ctrl_if
    import fp_mult_pkg::*;
#(
    parameter int WIDTH = MANT_W
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/mant_seq_mult_ctrl_ripple_adder.sv
// Ripple-carry adder built as a chain of full-adder cells, plus the cell itself.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_adder #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             cin,
    output logic [WIDTH-1:0] out,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (in0[i]),
            .b    (in1[i]),
            .cin  (carry[i]),
            .s    (out[i]),
            .cout (carry[i+1])
        );
    end
endmodule

// File: rtl/mant_seq_mult_ctrl.sv
// Shift-and-add mantissa multiplier: one shared adder iterated WIDTH times per product.
//
// state | meaning
// IDLE  | ready for operands, product register holds last value
// RUN   | one add/shift iteration per cycle, WIDTH cycles total
// DONE  | product presented until downstream accepts
module mant_seq_mult_ctrl
    import fp_mult_pkg::*;
#(
    parameter int WIDTH = MANT_W
) (
    input  logic              clk,
    input  logic              rst,
    mant_seq_mult_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   preg;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     add_in1;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;
    logic                 in_ready;
    logic                 out_valid;
    logic                 busy;

    assign add_in1 = preg[0] ? mcand : '0;

    ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .in0  (preg[2*WIDTH-1:WIDTH]),
        .in1  (add_in1),
        .cin  (1'b0),
        .out  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mcand <= '0;
            preg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand <= bus.a;
                        preg  <= {{WIDTH{1'b0}}, bus.b};
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    // carry out of the adder becomes the new MSB as the pair shifts right
                    preg <= {add_cout, add_sum, preg[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.product   = preg;

endmodule

// File: tb/tb_mant_seq_mult_ctrl.sv
// Scoreboard bench for the sequential mantissa multiplier controller.
module tb_mant_seq_mult_ctrl;
    localparam int W = 24;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    logic [2*W-1:0] sb[$];

    always #5 clk = ~clk;

    mant_seq_mult_ctrl_if #(.WIDTH(W)) bus ();

    mant_seq_mult_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] ex;
        logic [2*W-1:0] ey;
        ex = {{W{1'b0}}, x};
        ey = {{W{1'b0}}, y};
        return ex * ey;
    endfunction

    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y);
        bus.a = x;
        bus.b = y;
        bus.in_valid = 1'b1;
        sb.push_back(model(x, y));
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n, output bit to);
        n = 0;
        to = 1'b0;
        while (!bus.out_valid) begin
            tick();
            n++;
            if (n > 200) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.product !== '0) begin failures++; $display("FAIL reset_product got=%h exp=0", bus.product); end
    endtask

    task automatic test_basic();
        int n;
        bit to;
        logic [2*W-1:0] exp;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready got=%b exp=1", bus.in_ready); end
        accept(24'd3, 24'd5);
        wait_valid(n, to);
        checks++; if (to || n != W) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", n, W); end
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++; if (bus.product !== exp) begin failures++; $display("FAIL basic_product got=%h exp=%h", bus.product, exp); end
        checks++; if (bus.product !== 48'h00000000000F) begin failures++; $display("FAIL basic_literal got=%h exp=00000000000f", bus.product); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_idle_after got=%b%b exp=10", bus.in_ready, bus.out_valid); end
    endtask

    task automatic test_corners();
        logic [W-1:0] xs[2] = '{24'hFFFFFF, 24'h800000};
        logic [2*W-1:0] lit[2] = '{48'hFFFFFE000001, 48'h400000000000};
        int n;
        bit to;
        logic [2*W-1:0] exp;
        for (int i = 0; i < 2; i++) begin
            accept(xs[i], xs[i]);
            wait_valid(n, to);
            checks++; if (to) begin failures++; $display("FAIL corner_timeout idx=%0d got=timeout exp=out_valid", i); end
            exp = (sb.size() > 0) ? sb.pop_front() : 'x;
            checks++; if (bus.product !== exp || exp !== lit[i]) begin failures++; $display("FAIL corner_product idx=%0d got=%h exp=%h", i, bus.product, lit[i]); end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_zero();
        int n;
        bit to;
        logic [2*W-1:0] exp;
        accept(24'd0, 24'hABCDEF);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL zero_busy got=%b exp=1", bus.busy); end
        wait_valid(n, to);
        checks++; if (to || n != W) begin failures++; $display("FAIL zero_run_cycles got=%0d exp=%0d", n, W); end
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++; if (bus.product !== exp) begin failures++; $display("FAIL zero_product got=%h exp=%h", bus.product, exp); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_stall();
        int n;
        bit to;
        logic [2*W-1:0] exp;
        accept(24'h000007, 24'h000009);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            tick();
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_run_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        wait_valid(n, to);
        checks++; if (to || n + 10 != W) begin failures++; $display("FAIL stall_latency got=%0d exp=%0d", n + 10, W); end
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.product !== exp || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got=v%b p=%h r=%b exp=v1 p=%h r=0", i, bus.out_valid, bus.product, bus.in_ready, exp);
            end
            tick();
        end
        checks++; if (exp !== 48'h00000000003F) begin failures++; $display("FAIL stall_model got=%h exp=3f", exp); end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL stall_single_product got=v%b b%b exp=v0 b0", bus.out_valid, bus.busy); end
    endtask

    task automatic test_abort();
        int n;
        bit to;
        logic [2*W-1:0] exp;
        bus.a = 24'h123456;
        bus.b = 24'h654321;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL abort_state got=r%b v%b b%b exp=r1 v0 b0", bus.in_ready, bus.out_valid, bus.busy); end
        accept(24'd2, 24'd2);
        wait_valid(n, to);
        checks++; if (to || n != W) begin failures++; $display("FAIL abort_latency got=%0d exp=%0d", n, W); end
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++; if (bus.product !== exp || bus.product !== 48'd4) begin failures++; $display("FAIL abort_product got=%h exp=%h", bus.product, exp); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        bit to;
        logic [2*W-1:0] exp;
        bus.out_ready = 1'b1;
        bus.a = 24'hABC123;
        bus.b = 24'h00F00D;
        bus.in_valid = 1'b1;
        sb.push_back(model(24'hABC123, 24'h00F00D));
        tick();
        bus.a = 24'h7FFFFF;
        bus.b = 24'h000003;
        wait_valid(n, to);
        checks++; if (to || n != W) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=%0d", n, W); end
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++; if (bus.product !== exp) begin failures++; $display("FAIL b2b_first_product got=%h exp=%h", bus.product, exp); end
        tick();
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got=r%b b%b exp=r1 b0", bus.in_ready, bus.busy); end
        sb.push_back(model(24'h7FFFFF, 24'h000003));
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accept got=b%b r%b exp=b1 r0", bus.busy, bus.in_ready); end
        wait_valid(n, to);
        checks++; if (to || n != W) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=%0d", n, W); end
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++; if (bus.product !== exp) begin failures++; $display("FAIL b2b_second_product got=%h exp=%h", bus.product, exp); end
        tick();
        bus.out_ready = 1'b0;
        checks++; if (sb.size() != 0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0d,%b exp=0,0", sb.size(), bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_zero();
        test_stall();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mant_seq_mult_ctrl.md
Name: mant_seq_mult_ctrl

Overview:
- Sequential shift-and-add controller for the FP multiplier's mantissa product.
- Time-shares one WIDTH-bit ripple-carry adder, built from the existing full-adder cell, over WIDTH iterations. This replaces a full array multiplier.
- Sits between operand unpack (sign/exponent/mantissa split) and normalize/round.
- Uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 24, mantissa width including the hidden bit. Legal range is 2 to 32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands a/b present
- in_ready  output  1  controller can accept operands
- a  input  WIDTH  multiplicand mantissa
- b  input  WIDTH  multiplier mantissa
- out_valid  output  1  product valid
- out_ready  input  1  downstream accepts product
- product  output  2*WIDTH  unsigned a*b
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst sampled high at a clock edge):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - product register, multiplicand register and iteration counter are cleared to 0.
  - Reset mid-RUN or mid-DONE aborts the operation. The partial product is discarded and never presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at an edge (accept):
    - mcand<=a.
    - preg<={WIDTH zeros, b}: upper half is the accumulator, lower half is the multiplier.
    - cnt<=0.
    - Go to RUN.
  - With in_valid=0, stay in IDLE. Registers hold.
- RUN:
  - in_ready=0. in_valid is ignored, and a/b may change freely.
  - Each edge performs one iteration:
    - Adder inputs: in0=preg[2W-1:W], in1 = mcand if preg[0]=1, else 0. Carry-in is 0.
    - Adder result: {c, s} is WIDTH+1 bits.
    - Update: preg <= {c, s, preg[W-1:1]}, i.e. a right shift with the adder carry entering the MSB.
    - cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge, the final iteration executes and the state goes to DONE.
  - Exactly WIDTH iterations run. There is no early termination on zero operands.
  - cnt width is clog2(WIDTH). It must not wrap before reaching WIDTH-1.
- DONE:
  - out_valid=1. product=preg, held stable.
  - On out_ready=1 at an edge, go to IDLE.
  - While out_ready=0, product and out_valid hold indefinitely.
- Latency: out_valid first high after the WIDTH-th rising edge following the accept edge.
  - Minimum initiation interval is WIDTH+2 cycles: accept, WIDTH RUN cycles, one DONE cycle with out_ready=1.
- product is driven from preg in all states but is meaningful only while out_valid=1.
- Simultaneous events:
  - in_valid with out_ready in DONE: out_ready is honoured. Operands are not accepted until the following IDLE cycle.
  - rst with any other input: rst wins.
- Arithmetic: unsigned, no overflow possible, since 2*WIDTH bits hold the maximum product.

Decomposition:
- Shared package (fp_mult_pkg):
  - state enum {IDLE, RUN, DONE}, 2 bits.
  - MANT_W=24 constant, also used by the unpack/normalize blocks.
- One sub-module: ripple_adder (parameter WIDTH).
  - Ports: in0[WIDTH], in1[WIDTH], cin, out[WIDTH], cout.
  - Built as a chain of WIDTH full_adder instances.
  - The controller instantiates it once and holds all sequential state itself.

Test Plan:
- WIDTH=24, a=3, b=5, out_ready=1 -> out_valid rises 24 edges after accept, product=0x00000000000F, back to IDLE one cycle later.
- a=0xFFFFFF, b=0xFFFFFF -> product=0xFFFFFE000001. a=0x800000, b=0x800000 -> product=0x400000000000.
- a=0, b=0xABCDEF -> product=0; still takes 24 RUN cycles (busy high 24 cycles).
- Accept a=0x000007, b=0x000009; toggle in_valid with new operands during RUN; hold out_ready=0 for 10 cycles in DONE -> product stays 0x00000000003F, in_ready stays 0, only one product delivered.
- Assert rst at iteration 12 -> next cycle in_ready=1, out_valid=0, busy=0. A new accept of a=2, b=2 yields product=4 with normal latency.
- Back-to-back: in_valid held high with two operand pairs -> second accept occurs exactly one cycle after the first DONE handshake. Both products are correct.
